// File: rtl/resource_dispenser_if.sv
// resource_dispenser_if: load, request/response handshake and pool-level signals for resource_dispenser
interface resource_dispenser_if #(
  parameter int ENERGY_W = 8,
  parameter int TRACER_W = 6,
  parameter int FLUID_W  = 4
);
  logic                load_en;
  logic [ENERGY_W-1:0] load_energy;
  logic [TRACER_W-1:0] load_tracer;
  logic [FLUID_W-1:0]  load_fluid;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_type;
  logic [7:0]          req_amount;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_grant;
  logic [7:0]          rsp_remaining;
  logic [ENERGY_W-1:0] energy_lvl;
  logic [TRACER_W-1:0] tracer_lvl;
  logic [FLUID_W-1:0]  fluid_lvl;
  modport master (
    output load_en, load_energy, load_tracer, load_fluid, req_valid, req_type, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_grant, rsp_remaining, energy_lvl, tracer_lvl, fluid_lvl
  );
  modport slave (
    input  load_en, load_energy, load_tracer, load_fluid, req_valid, req_type, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_grant, rsp_remaining, energy_lvl, tracer_lvl, fluid_lvl
  );
endinterface

// File: rtl/resource_dispenser.sv
// resource_dispenser: three-pool spend arbiter (IDLE/CHECK/RESP); clk, rst_n (sync active-low), bus (slave), deny_count when DISPENSER_DENY_CNT_EN is defined
module resource_dispenser #(
  parameter int ENERGY_W = 8,
  parameter int TRACER_W = 6,
  parameter int FLUID_W  = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef DISPENSER_DENY_CNT_EN
  output logic [7:0] deny_count,
`endif
  resource_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t state_q, state_d;
  logic [ENERGY_W-1:0] energy_q, energy_d;
  logic [TRACER_W-1:0] tracer_q, tracer_d;
  logic [FLUID_W-1:0] fluid_q, fluid_d;
  logic [1:0] type_q, type_d;
  logic [7:0] amt_q, amt_d, rem_q, rem_d, sel_lvl, rem;
  logic grant_q, grant_d, fits, grant, accept, ld, chk;
  assign accept = state_q == IDLE && bus.req_valid;
  assign ld = state_q == IDLE && bus.load_en;
  assign chk = state_q == CHECK;
  // amount must not carry bits above the pool width, otherwise truncation could fake a grant
  assign fits = type_q == 2'd0 ? (32'(amt_q) >> ENERGY_W) == 32'd0 :
                type_q == 2'd1 ? (32'(amt_q) >> TRACER_W) == 32'd0 :
                type_q == 2'd2 ? (32'(amt_q) >> FLUID_W) == 32'd0 : 1'b0;
  assign sel_lvl = type_q == 2'd0 ? 8'(energy_q) :
                   type_q == 2'd1 ? 8'(tracer_q) :
                   type_q == 2'd2 ? 8'(fluid_q) : 8'd0;
  assign grant = type_q != 2'd3 && fits && amt_q <= sel_lvl;
  assign rem = grant ? sel_lvl - amt_q : sel_lvl;
  always_comb begin
    state_d = accept ? CHECK : chk ? RESP : (state_q == RESP && bus.rsp_ready) ? IDLE : state_q;
    energy_d = ld ? bus.load_energy : (chk && grant && type_q == 2'd0) ? energy_q - ENERGY_W'(amt_q) : energy_q;
    tracer_d = ld ? bus.load_tracer : (chk && grant && type_q == 2'd1) ? tracer_q - TRACER_W'(amt_q) : tracer_q;
    fluid_d = ld ? bus.load_fluid : (chk && grant && type_q == 2'd2) ? fluid_q - FLUID_W'(amt_q) : fluid_q;
    type_d = accept ? bus.req_type : type_q;
    amt_d = accept ? bus.req_amount : amt_q;
    grant_d = chk ? grant : grant_q;
    rem_d = chk ? rem : rem_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      energy_q <= '0;
      tracer_q <= '0;
      fluid_q <= '0;
      type_q <= '0;
      amt_q <= '0;
      grant_q <= 1'b0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      energy_q <= energy_d;
      tracer_q <= tracer_d;
      fluid_q <= fluid_d;
      type_q <= type_d;
      amt_q <= amt_d;
      grant_q <= grant_d;
      rem_q <= rem_d;
    end
  end
`ifdef DISPENSER_DENY_CNT_EN
  logic [7:0] deny_q, deny_d;
  assign deny_d = (chk && !grant && deny_q != 8'hff) ? deny_q + 8'd1 : deny_q;
  always_ff @(posedge clk) begin
    if (!rst_n) deny_q <= '0;
    else deny_q <= deny_d;
  end
  assign deny_count = deny_q;
`endif
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_grant = grant_q;
  assign bus.rsp_remaining = rem_q;
  assign bus.energy_lvl = energy_q;
  assign bus.tracer_lvl = tracer_q;
  assign bus.fluid_lvl = fluid_q;
endmodule

// File: doc/resource_dispenser.md
RESOURCE_DISPENSER -- requirements
Module: resource_dispenser

Interface
- REQ-001: Parameters SHALL be: ENERGY_W, default 8, energy pool width; TRACER_W, default 6, tracer pool width; FLUID_W, default 4, fluid pool width.
- REQ-002: Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst_n  input  1  synchronous active-low reset.
- REQ-005: load_en  input  1  load all three pools from the load_* inputs.
- REQ-006: load_energy  input  ENERGY_W  energy load value.
- REQ-007: load_tracer  input  TRACER_W  tracer load value.
- REQ-008: load_fluid  input  FLUID_W  fluid load value.
- REQ-009: req_valid  input  1  spend request valid.
- REQ-010: req_ready  output  1  dispenser can accept a request.
- REQ-011: req_type  input  2  0=energy, 1=tracer, 2=fluid, 3=reserved.
- REQ-012: req_amount  input  8  units requested.
- REQ-013: rsp_valid  output  1  response valid.
- REQ-014: rsp_ready  input  1  response consumed.
- REQ-015: rsp_grant  output  1  1=spend performed, 0=denied.
- REQ-016: rsp_remaining  output  8  selected pool level after the decision, zero-extended.
- REQ-017: energy_lvl, tracer_lvl, fluid_lvl  output  ENERGY_W/TRACER_W/FLUID_W  current pool levels.

Function
- REQ-018: The FSM SHALL have exactly three states: IDLE, CHECK, RESP.
- REQ-019: req_ready SHALL equal 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and req_type and req_amount are captured on that edge.
- REQ-020: Transitions SHALL be: IDLE->CHECK on accept; CHECK->RESP unconditionally after one cycle; RESP->IDLE on rsp_ready=1.
- REQ-021: In CHECK, grant SHALL be 1 iff req_type!=3, the captured amount fits the selected pool width (upper bits zero), and amount <= pool level.
- REQ-022: On the CHECK->RESP edge, a granted request SHALL subtract the amount from the selected pool (no borrow possible); a denied request SHALL leave all pools unchanged.
- REQ-023: rsp_valid SHALL rise on the second edge after acceptance and remain 1, with rsp_grant and rsp_remaining stable, until the rsp_ready handshake.
- REQ-024: An amount of 0 SHALL be granted with no pool change; for type 3, rsp_remaining SHALL be 0.
- REQ-025: load_en SHALL take effect only in IDLE and SHALL be ignored in CHECK and RESP.
- REQ-026: When load_en and an accept occur in the same IDLE cycle, the load SHALL apply, and the request SHALL be checked against the loaded values.
- REQ-027: Throughput SHALL be at most one request per three cycles; back-to-back requests SHALL see the prior deduction.

Reset
- REQ-028: While rst_n=0 at a clock edge, the FSM SHALL enter IDLE, all pools SHALL go to 0, and rsp_valid, rsp_grant and rsp_remaining SHALL go to 0.
- REQ-029: req_ready SHALL be 1 from the first edge with rst_n=0.
- REQ-030: A reset in CHECK or RESP SHALL abandon the transaction with no response; a deduction already committed in RESP is cleared along with the pools.

Configuration
- REQ-031: With DISPENSER_DENY_CNT_EN defined, an output deny_count of 8 bits SHALL increment on each CHECK->RESP edge with grant=0, saturate at 255, and reset to 0.
- REQ-032: Without DISPENSER_DENY_CNT_EN, the deny_count port and its logic SHALL be absent, and all other behaviour is identical.

Verification
- REQ-033: Reset, then load 200/40/9 and request energy 50 -> rsp_grant=1, rsp_remaining=150, energy_lvl=150, rsp_valid rises 2 cycles after accept.
- REQ-034: Fluid=9, request fluid 10 -> rsp_grant=0, rsp_remaining=9, fluid unchanged; with DISPENSER_DENY_CNT_EN, deny_count=1.
- REQ-035: Tracer=40, request tracer 64 (exceeds 6-bit width) -> denied; request type 3 amount 1 -> denied, rsp_remaining=0.
- REQ-036: Hold rsp_ready=0 for 5 cycles in RESP with load_en=1 -> response stable, req_ready=0, pools unchanged; rsp_ready=1 -> IDLE next cycle.
- REQ-037: Same-cycle load_energy=30 with accept of energy 30 -> grant, energy_lvl=0; rst_n=0 during CHECK -> no response, all levels 0.
